// File: rtl/debug_probe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debug_probe_pkg
//  Description : Shared definitions for the debug_probe block: sequencer
//                state encoding, ASCII framing constants and the
//                nibble-to-hex-character helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package debug_probe_pkg;

    // Frame sequencer states.
    //   ST_IDLE      : waiting for a halt rising edge
    //   ST_LOAD      : snapshot valid, first character handed to the UART
    //   ST_SEND_CHAR : UART shifting a character out
    //   ST_NEXT      : final stop-bit cycle; next character or frame decided
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_SEND_CHAR = 2'd2,
        ST_NEXT      = 2'd3
    } state_t;

    localparam logic [7:0] c_ascii_space = 8'h20;
    localparam logic [7:0] c_ascii_cr    = 8'h0D;
    localparam logic [7:0] c_ascii_lf    = 8'h0A;

    // 0..9 -> '0'..'9', 10..15 -> 'A'..'F' (uppercase).
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage : debug_probe_pkg
`default_nettype wire

// File: rtl/debug_probe_if.sv
`default_nettype none
// ============================================================================
//  Module      : debug_probe_if
//  Description : Probe-side bundle of debug_probe: capture trigger, mode,
//                probe channels, UART line and busy flag.
//                master : environment driving halt/cont/probe
//                slave  : the debug_probe block
//  Revision    : 1.0 - initial release
// ============================================================================
interface debug_probe_if #(
    parameter int N_CH = 3
) ();
    logic                 halt;   // capture trigger (synchronous to clk)
    logic                 cont;   // 0 single-shot, 1 continuous while halt
    logic [16*N_CH-1:0]   probe;  // channel k at [16k+15:16k]
    logic                 tx;     // UART 8N1 line, idle high
    logic                 busy;   // frame captured or in flight

    modport master (
        output halt,
        output cont,
        output probe,
        input  tx,
        input  busy
    );

    modport slave (
        input  halt,
        input  cont,
        input  probe,
        output tx,
        output busy
    );
endinterface : debug_probe_if
`default_nettype wire

// File: rtl/debug_probe_uart.sv
`default_nettype none
// ============================================================================
//  Module      : debug_probe_uart
//  Description : 8N1 serializer. A byte is accepted on i_valid & o_ready; its
//                start bit appears on o_tx in the following cycle. o_ready is
//                also high during the last cycle of a stop bit, so a byte
//                offered then follows with no idle gap.
//  Ports       : clk, rst_n     - clock, asynchronous active-low reset
//                i_data/i_valid - byte to send / offer strobe
//                o_ready        - byte will be accepted this cycle
//                o_stop_next    - next cycle is the last cycle of the stop bit
//                o_tx           - serial line (registered, idle high)
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_probe_uart #(
    parameter int CLK_DIV = 104
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic [7:0] i_data,
    input  wire logic       i_valid,
    output logic            o_ready,
    output logic            o_stop_next,
    output logic            o_tx
);

    localparam logic [15:0] c_div_last    = 16'(CLK_DIV - 1);
    localparam logic [15:0] c_div_prelast = 16'(CLK_DIV - 2);
    localparam logic [3:0]  c_stop_bit    = 4'd9;

    logic        active_q, active_d;
    logic [3:0]  bit_q,    bit_d;     // 0 start, 1..8 data, 9 stop
    logic [15:0] div_q,    div_d;     // cycle within current bit
    logic [8:0]  shift_q,  shift_d;   // remaining data bits then stop bit
    logic        tx_q,     tx_d;

    logic        w_bit_end;
    logic        w_last;

    always_comb begin
        active_d    = active_q;
        bit_d       = bit_q;
        div_d       = div_q;
        shift_d     = shift_q;
        tx_d        = tx_q;

        w_bit_end   = active_q && (div_q == c_div_last);
        w_last      = w_bit_end && (bit_q == c_stop_bit);
        o_ready     = !active_q || w_last;
        o_stop_next = active_q && (bit_q == c_stop_bit) && (div_q == c_div_prelast);

        if (active_q) begin
            if (w_bit_end) begin
                div_d = '0;
                if (bit_q == c_stop_bit) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b1, shift_q[8:1]};
                    bit_d   = bit_q + 4'd1;
                end
            end else begin
                div_d = div_q + 16'd1;
            end
        end

        // A new byte overrides the end-of-stop behaviour above.
        if (i_valid && o_ready) begin
            active_d = 1'b1;
            tx_d     = 1'b0;
            shift_d  = {1'b1, i_data};
            bit_d    = '0;
            div_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            bit_q    <= '0;
            div_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

    assign o_tx = tx_q;

endmodule : debug_probe_uart
`default_nettype wire

// File: rtl/debug_probe.sv
`default_nettype none
// ============================================================================
//  Module      : debug_probe
//  Description : On a halt rising edge, snapshots N_CH 16-bit probe channels
//                and prints them over a UART 8N1 line as
//                "HHHH HHHH ...\r\n" (channel 0 first, MS nibble first).
//                With cont=1 and halt still high at frame end, a new
//                snapshot is taken immediately and another frame follows.
//  Ports       : clk    - sole clock
//                rst_n  - asynchronous active-low reset
//                dbg    - debug_probe_if.slave (halt, cont, probe, tx, busy)
//  Build macro : DEBUG_PROBE_CHECKSUM_EN - append " HH" (XOR of all snapshot
//                bytes) before CR LF.
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_probe
    import debug_probe_pkg::*;
#(
    parameter int N_CH    = 3,
    parameter int CLK_DIV = 104
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    debug_probe_if.slave   dbg
);

    // Characters covering the channel fields and the separating spaces.
    localparam int c_data_chars = 5 * N_CH - 1;
`ifdef DEBUG_PROBE_CHECKSUM_EN
    localparam int c_frame_len  = 5 * N_CH + 4;
`else
    localparam int c_frame_len  = 5 * N_CH + 1;
`endif

    state_t              state_q, state_d;
    logic                halt_q,  halt_d;
    logic [16*N_CH-1:0]  snap_q,  snap_d;
    logic [5:0]          char_q,  char_d;   // index of the next character to hand over
    logic                busy_q,  busy_d;

    logic                w_trig;
    logic                w_valid;
    logic                w_ready;
    logic                w_stop_next;
    logic                w_tx;
    logic [7:0]          w_char;

    int                  w_pos;
    int                  w_ch;
    int                  w_dig;
    int                  w_off;

`ifdef DEBUG_PROBE_CHECKSUM_EN
    logic [7:0]          w_cks;

    always_comb begin
        w_cks = '0;
        for (int i = 0; i < 2 * N_CH; i++) begin
            w_cks = w_cks ^ snap_q[8*i +: 8];
        end
    end
`endif

    // Character at position char_q of the frame being sent.
    always_comb begin
        w_pos  = int'(char_q);
        w_ch   = w_pos / 5;
        w_dig  = w_pos % 5;          // 0..3 hex digit, 4 separator
        w_off  = w_pos - c_data_chars;
        w_char = c_ascii_lf;
        if (w_pos < c_data_chars) begin
            if (w_dig == 4) begin
                w_char = c_ascii_space;
            end else begin
                w_char = hex_ascii(snap_q[16*w_ch + 4*(3 - w_dig) +: 4]);
            end
        end else begin
`ifdef DEBUG_PROBE_CHECKSUM_EN
            case (w_off)
                0:       w_char = c_ascii_space;
                1:       w_char = hex_ascii(w_cks[7:4]);
                2:       w_char = hex_ascii(w_cks[3:0]);
                3:       w_char = c_ascii_cr;
                default: w_char = c_ascii_lf;
            endcase
`else
            if (w_off == 0) begin
                w_char = c_ascii_cr;
            end
`endif
        end
    end

    // Sequencer. NEXT coincides with the last stop-bit cycle of a character,
    // which is the UART's accept window for a gap-free next character and
    // the point where the frame is closed or restarted.
    always_comb begin
        state_d = state_q;
        halt_d  = dbg.halt;
        snap_d  = snap_q;
        char_d  = char_q;
        busy_d  = busy_q;
        w_valid = 1'b0;
        w_trig  = dbg.halt && !halt_q;

        case (state_q)
            ST_IDLE: begin
                if (w_trig) begin
                    snap_d  = dbg.probe;
                    busy_d  = 1'b1;
                    char_d  = '0;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                w_valid = 1'b1;
                if (w_ready) begin
                    char_d  = char_q + 6'd1;
                    state_d = ST_SEND_CHAR;
                end
            end

            ST_SEND_CHAR: begin
                if (w_stop_next) begin
                    state_d = ST_NEXT;
                end
            end

            ST_NEXT: begin
                if (int'(char_q) < c_frame_len) begin
                    w_valid = 1'b1;
                    if (w_ready) begin
                        char_d  = char_q + 6'd1;
                        state_d = ST_SEND_CHAR;
                    end
                end else if (dbg.cont && dbg.halt) begin
                    // Back-to-back capture; busy stays high.
                    snap_d  = dbg.probe;
                    char_d  = '0;
                    state_d = ST_LOAD;
                end else begin
                    busy_d  = 1'b0;
                    char_d  = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            halt_q  <= 1'b0;
            snap_q  <= '0;
            char_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
            snap_q  <= snap_d;
            char_q  <= char_d;
            busy_q  <= busy_d;
        end
    end

    debug_probe_uart #(
        .CLK_DIV (CLK_DIV)
    ) u_uart (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_data      (w_char),
        .i_valid     (w_valid),
        .o_ready     (w_ready),
        .o_stop_next (w_stop_next),
        .o_tx        (w_tx)
    );

    assign dbg.tx   = w_tx;
    assign dbg.busy = busy_q;

endmodule : debug_probe
`default_nettype wire

// File: tb/tb_debug_probe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debug_probe
//  Description : Self-checking bench for debug_probe. Instance A: N_CH=2,
//                CLK_DIV=4. Instance B: N_CH=1, CLK_DIV=2. Frames are
//                checked bit-by-bit against hand-written expected text.
//                Honours DEBUG_PROBE_CHECKSUM_EN for the expected frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_probe;

    localparam logic [7:0] c_cr = 8'h0D;
    localparam logic [7:0] c_lf = 8'h0A;

`ifdef DEBUG_PROBE_CHECKSUM_EN
    localparam int           c_len2     = 14;
    localparam int           c_len1     = 9;
    localparam logic [127:0] c_txt_aaaa = {"AAAA 9999 00", c_cr, c_lf};
    localparam logic [127:0] c_txt_1234 = {"1234 0000 26", c_cr, c_lf};
    localparam logic [127:0] c_txt_c0de = {"C0DE 0001 1F", c_cr, c_lf};
    localparam logic [127:0] c_txt_0f0f = {"0F0F 00", c_cr, c_lf};
    localparam logic [127:0] c_txt_7a5b = {"7A5B 21", c_cr, c_lf};
    localparam logic [127:0] c_txt_old  = {"1234 5678 08", c_cr, c_lf};
    localparam logic [127:0] c_txt_new  = {"CAFE BEEF 65", c_cr, c_lf};
`else
    localparam int           c_len2     = 11;
    localparam int           c_len1     = 6;
    localparam logic [127:0] c_txt_aaaa = {"AAAA 9999", c_cr, c_lf};
    localparam logic [127:0] c_txt_1234 = {"1234 0000", c_cr, c_lf};
    localparam logic [127:0] c_txt_c0de = {"C0DE 0001", c_cr, c_lf};
    localparam logic [127:0] c_txt_0f0f = {"0F0F", c_cr, c_lf};
    localparam logic [127:0] c_txt_7a5b = {"7A5B", c_cr, c_lf};
    localparam logic [127:0] c_txt_old  = {"1234 5678", c_cr, c_lf};
    localparam logic [127:0] c_txt_new  = {"CAFE BEEF", c_cr, c_lf};
`endif

    typedef struct {
        int           sel;     // 0 = instance A, 1 = instance B
        logic [31:0]  probe;
        logic [127:0] text;
        int           len;
    } vec_t;

    logic clk;
    logic rst_n;
    int   cur;
    int   errors;
    int   checks;

    int          ev_cyc  [4];
    int          ev_kind [4];   // 1 probe, 2 halt, 3 cont
    logic [31:0] ev_val  [4];

    vec_t vecs [5];

    debug_probe_if #(.N_CH(2)) ifa ();
    debug_probe_if #(.N_CH(1)) ifb ();

    debug_probe #(.N_CH(2), .CLK_DIV(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .dbg   (ifa)
    );

    debug_probe #(.N_CH(1), .CLK_DIV(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .dbg   (ifb)
    );

    logic tx_s;
    logic busy_s;
    assign tx_s   = (cur == 1) ? ifb.tx   : ifa.tx;
    assign busy_s = (cur == 1) ? ifb.busy : ifa.busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_probe(input logic [31:0] v);
        if (cur == 1) ifb.probe = v[15:0];
        else          ifa.probe = v;
    endtask

    task automatic set_halt(input logic v);
        if (cur == 1) ifb.halt = v;
        else          ifa.halt = v;
    endtask

    task automatic set_cont(input logic v);
        if (cur == 1) ifb.cont = v;
        else          ifa.cont = v;
    endtask

    task automatic clear_events();
        for (int k = 0; k < 4; k++) begin
            ev_cyc[k]  = -1;
            ev_kind[k] = 0;
            ev_val[k]  = '0;
        end
    endtask

    task automatic apply_events(input int n);
        for (int k = 0; k < 4; k++) begin
            if (ev_cyc[k] == n) begin
                case (ev_kind[k])
                    1:       set_probe(ev_val[k]);
                    2:       set_halt(ev_val[k][0]);
                    3:       set_cont(ev_val[k][0]);
                    default: ;
                endcase
            end
        end
    endtask

    // Raise halt just before a rising edge; drop it after unless held.
    task automatic trigger(input logic [31:0] probe, input logic hold, input string tag);
        @(negedge clk);
        set_probe(probe);
        set_halt(1'b1);
        chk({tag, "_pre_busy"}, {31'd0, busy_s}, 32'd0);
        @(posedge clk);
        #1;
        if (!hold) set_halt(1'b0);
    endtask

    // Starts at the LOAD cycle; checks every cycle of every bit of the frame.
    task automatic expect_frame(input logic [127:0] text, input int len, input string tag);
        int         d;
        int         n;
        int         busy_cnt;
        int         unstable;
        logic [9:0] got;
        logic [7:0] ch;
        d        = (cur == 1) ? 2 : 4;
        n        = 0;
        unstable = 0;
        @(negedge clk);
        chk({tag, "_load_busy"}, {31'd0, busy_s}, 32'd1);
        chk({tag, "_load_tx"},   {31'd0, tx_s},   32'd1);
        busy_cnt = busy_s ? 1 : 0;
        for (int i = 0; i < len; i++) begin
            got = '0;
            for (int b = 0; b < 10; b++) begin
                for (int c = 0; c < d; c++) begin
                    @(negedge clk);
                    if (busy_s) busy_cnt++;
                    if (c == 0)               got[b] = tx_s;
                    else if (tx_s !== got[b]) unstable++;
                    apply_events(n);
                    n++;
                end
            end
            ch = text[8*(len-1-i) +: 8];
            chk($sformatf("%s_char%0d", tag, i), {22'd0, got}, {22'd0, 1'b1, ch, 1'b0});
        end
        chk({tag, "_bit_width"},   unstable, 32'd0);
        chk({tag, "_busy_cycles"}, busy_cnt, 1 + 10 * len * d);
    endtask

    task automatic after_frame(input string tag);
        @(negedge clk);
        chk({tag, "_busy_low"}, {31'd0, busy_s}, 32'd0);
        chk({tag, "_tx_idle"},  {31'd0, tx_s},   32'd1);
    endtask

    task automatic expect_idle(input string tag, input int cycles);
        int bad;
        bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (busy_s || !tx_s) bad++;
        end
        chk(tag, bad, 32'd0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        cur       = 0;
        rst_n     = 1'b0;
        ifa.halt  = 1'b0;
        ifa.cont  = 1'b0;
        ifa.probe = '0;
        ifb.halt  = 1'b0;
        ifb.cont  = 1'b0;
        ifb.probe = '0;
        clear_events();

        vecs[0] = '{0, {16'h9999, 16'hAAAA}, c_txt_aaaa, c_len2};
        vecs[1] = '{0, {16'h0000, 16'h1234}, c_txt_1234, c_len2};
        vecs[2] = '{1, 32'h0000_0F0F,        c_txt_0f0f, c_len1};
        vecs[3] = '{0, {16'h0001, 16'hC0DE}, c_txt_c0de, c_len2};
        vecs[4] = '{1, 32'h0000_7A5B,        c_txt_7a5b, c_len1};

        repeat (3) @(negedge clk);
        chk("reset_a_tx",   {31'd0, ifa.tx},   32'd1);
        chk("reset_a_busy", {31'd0, ifa.busy}, 32'd0);
        chk("reset_b_tx",   {31'd0, ifb.tx},   32'd1);
        chk("reset_b_busy", {31'd0, ifb.busy}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single-shot frames from the vector table.
        for (int v = 0; v < 5; v++) begin
            cur = vecs[v].sel;
            clear_events();
            trigger(vecs[v].probe, 1'b0, $sformatf("vec%0d", v));
            expect_frame(vecs[v].text, vecs[v].len, $sformatf("vec%0d", v));
            after_frame($sformatf("vec%0d", v));
            repeat (5) @(negedge clk);
        end

        // Halt re-pulsed twice mid-frame in single-shot mode: one frame only.
        cur = 0;
        clear_events();
        ev_cyc[0] = 20;  ev_kind[0] = 2; ev_val[0] = 32'd1;
        ev_cyc[1] = 23;  ev_kind[1] = 2; ev_val[1] = 32'd0;
        ev_cyc[2] = 200; ev_kind[2] = 2; ev_val[2] = 32'd1;
        ev_cyc[3] = 204; ev_kind[3] = 2; ev_val[3] = 32'd0;
        trigger({16'h0001, 16'hC0DE}, 1'b0, "pulses");
        expect_frame(c_txt_c0de, c_len2, "pulses");
        after_frame("pulses");
        expect_idle("pulses_quiet", 60);

        // Continuous: probe changes mid-frame; second frame shows new value.
        // cont drops during frame 2 with halt still high, so it stops after.
        cur = 0;
        set_cont(1'b1);
        clear_events();
        ev_cyc[0] = 100; ev_kind[0] = 1; ev_val[0] = {16'hBEEF, 16'hCAFE};
        trigger({16'h5678, 16'h1234}, 1'b1, "cont1");
        expect_frame(c_txt_old, c_len2, "cont1");
        clear_events();
        ev_cyc[0] = 10; ev_kind[0] = 3; ev_val[0] = 32'd0;
        expect_frame(c_txt_new, c_len2, "cont2");
        after_frame("cont_end");
        expect_idle("cont_quiet", 30);
        set_halt(1'b0);
        repeat (3) @(negedge clk);

        // Reset during the start bit of the third character.
        cur = 0;
        clear_events();
        trigger({16'h9999, 16'hAAAA}, 1'b0, "rst");
        @(negedge clk);
        repeat (81) @(negedge clk);
        chk("rst_pre_start_bit", {31'd0, tx_s}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_tx",   {31'd0, tx_s},   32'd1);
        chk("rst_async_busy", {31'd0, busy_s}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_idle("rst_quiet", 50);
        trigger({16'h9999, 16'hAAAA}, 1'b0, "post_rst");
        expect_frame(c_txt_aaaa, c_len2, "post_rst");
        after_frame("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_debug_probe
`default_nettype wire
